ahb_lite_master_arbiter: RTL and testbench
==========================================

Name: ahb_lite_master_arbiter

Overview:
- Two-master arbiter and bus multiplexer in front of the AHB-Lite fabric (decoder, slave mux, memory controller).
- Lets two bus masters, e.g. the testbench driver and a DMA engine, share the single AHB-Lite master port.
- Round-robin grant with HLOCK support and a beat-limit preemption counter.
- Tracks address-phase and data-phase ownership separately so pipelined transfers hand over cleanly.

Parameters:
ADDR_WIDTH, 32, width of HADDR
DATA_WIDTH, 32, width of HWDATA/HRDATA
MAX_HOLD, 8, accepted beats a master may own the bus while the other master requests (range 1..255)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
m0_req  input  1  master 0 bus request
m0_lock  input  1  master 0 locked-sequence request (HLOCK)
m0_haddr  input  ADDR_WIDTH  master 0 address
m0_htrans  input  2  master 0 transfer type
m0_hwrite  input  1  master 0 write
m0_hsize  input  3  master 0 size
m0_hburst  input  3  master 0 burst
m0_hwdata  input  DATA_WIDTH  master 0 write data
m0_grant  output  1  master 0 owns address phase
m0_hready  output  1  HREADY as seen by master 0
m1_*  (same 10 signals as m0_*)  —  master 1
haddr  output  ADDR_WIDTH  to fabric
htrans  output  2  to fabric
hwrite  output  1  to fabric
hsize  output  3  to fabric
hburst  output  3  to fabric
hmastlock  output  1  to fabric
hwdata  output  DATA_WIDTH  to fabric
hready  input  1  HREADY from slave mux
hrdata  input  DATA_WIDTH  from slave mux (broadcast to both masters externally)

Behaviour:
- Interface: one clock, `clk`. `reset` is synchronous and active-high. All state updates on the rising edge of `clk`.
- State: `owner` (address-phase owner, 0/1), `dp_owner` (data-phase owner), `dp_valid`, `last` (round-robin pointer), `hold_cnt` (8 bits).
- Reset values:
  - owner=0, dp_owner=0, dp_valid=0, last=1, hold_cnt=0.
  - m0_grant=1, m1_grant=0 (bus parked on master 0).
  - Muxed outputs follow master 0.
  - hmastlock = m0_lock.
- Address mux: haddr/htrans/hwrite/hsize/hburst and hmastlock are driven combinationally from the `owner` master.
- Data mux: hwdata is driven combinationally from `dp_owner`.
- Ready routing: mX_hready = hready when X==owner, or when (dp_valid and X==dp_owner); otherwise 0.
- Phase tracking: on a cycle with hready=1:
  - dp_owner <= owner.
  - dp_valid <= htrans[1] (NONSEQ or SEQ was accepted).
- Hold counter:
  - On hready=1 with htrans[1]=1: hold_cnt increments, saturating at 255.
  - hold_cnt clears whenever owner changes.
- Arbitration point: a cycle with hready=1. Arbitration is evaluated only there; no grant change while hready=0.
- Switch condition: at an arbitration point, with O = owner and N = other master, switch when N_req=1 and O's lock=0 and any of:
  - O_req=0;
  - O htrans==IDLE;
  - hold_cnt+(htrans[1]?1:0) >= MAX_HOLD.
- On a switch: owner <= N, last <= N, hold_cnt <= 0. The new grant is visible the next cycle. The old master's pending SEQ is not accepted (early burst termination); it must re-issue with NONSEQ.
- Locked sequences: while O lock=1, no switch occurs regardless of hold_cnt.
- Simultaneous requests while O has req=0: grant goes to the master != last.
- No requesters: owner is unchanged (parking); the parked master must drive IDLE.
- Grants are one-hot at all times. mX_grant = (owner==X).
- Reset mid-transfer: all state returns to reset values in the same edge. dp_valid=0, so neither master sees a stale data-phase ready.

Test Plan:
- Reset, then m0_req=1, m0 issues NONSEQ write to 0x0000_0010 data 0xDEAD_BEEF, hready=1 → m0_grant=1, haddr=0x10 in the same cycle, hwdata=0xDEADBEEF the next cycle, m1_hready=0.
- m0 idle with req=0, m1_req=1 → m1_grant=1 one cycle after the arbitration point; m0_grant=0; hold_cnt=0.
- Both masters request continuous INCR bursts, MAX_HOLD=8 → ownership alternates every 8 accepted beats; hwdata follows dp_owner with a 1-cycle lag; no beat is lost or duplicated at the fabric.
- m0_lock=1 during a 16-beat locked burst while m1_req=1 → no switch before m0_lock drops; hmastlock=1 throughout; m1_hready=0.
- hready held low 3 cycles at a switch point → grant is unchanged until hready=1, then switches; the stalled data phase completes for the old master (its mX_hready=1 on that cycle).
- reset asserted mid-burst by m1 → next cycle m0_grant=1, m1_grant=0, m1_hready=0, htrans follows m0.

Source files
------------

// File: rtl/ahb_lite_master_arbiter.sv
// ahb_lite_master_arbiter
//   Two-master arbiter and bus multiplexer in front of a single AHB-Lite
//   master port. Round-robin ownership, HLOCK support and a beat-limit
//   preemption counter. Address-phase and data-phase ownership are tracked
//   separately so pipelined transfers hand over cleanly.
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   mX_req / mX_lock      bus request / locked-sequence request (X = 0, 1)
//   mX_haddr..mX_hwdata   master X address/control/write data
//   mX_grant              master X owns the address phase
//   mX_hready             HREADY as seen by master X
//   haddr..hwdata         muxed AHB-Lite signals to the fabric
//   hmastlock             lock of the address-phase owner
//   hready, hrdata        from the slave mux (hrdata is broadcast outside)
//   dbg_*                 arbiter state for observation
//
// Handshake: a transfer presented on the address phase is accepted on the
// rising edge where hready=1 and htrans[1]=1 (NONSEQ/SEQ). Its data phase
// occupies the following hready=1 cycle. hready=1 is also the only point
// at which ownership may change.
module ahb_lite_master_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_HOLD   = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  m0_req,
    input  logic                  m0_lock,
    input  logic [ADDR_WIDTH-1:0] m0_haddr,
    input  logic [1:0]            m0_htrans,
    input  logic                  m0_hwrite,
    input  logic [2:0]            m0_hsize,
    input  logic [2:0]            m0_hburst,
    input  logic [DATA_WIDTH-1:0] m0_hwdata,
    output logic                  m0_grant,
    output logic                  m0_hready,
    input  logic                  m1_req,
    input  logic                  m1_lock,
    input  logic [ADDR_WIDTH-1:0] m1_haddr,
    input  logic [1:0]            m1_htrans,
    input  logic                  m1_hwrite,
    input  logic [2:0]            m1_hsize,
    input  logic [2:0]            m1_hburst,
    input  logic [DATA_WIDTH-1:0] m1_hwdata,
    output logic                  m1_grant,
    output logic                  m1_hready,
    output logic [ADDR_WIDTH-1:0] haddr,
    output logic [1:0]            htrans,
    output logic                  hwrite,
    output logic [2:0]            hsize,
    output logic [2:0]            hburst,
    output logic                  hmastlock,
    output logic [DATA_WIDTH-1:0] hwdata,
    input  logic                  hready,
    input  logic [DATA_WIDTH-1:0] hrdata,
    output logic                  dbg_owner,
    output logic                  dbg_dp_owner,
    output logic                  dbg_dp_valid,
    output logic                  dbg_last,
    output logic [7:0]            dbg_hold_cnt
);

    localparam logic [1:0] HTRANS_IDLE = 2'b00;

    logic       owner, owner_nxt;
    logic       dp_owner, dp_owner_nxt;
    logic       dp_valid, dp_valid_nxt;
    logic       last, last_nxt;
    logic [7:0] hold_cnt, hold_nxt;

    logic       o_req, n_req, o_lock;
    logic [8:0] beats;
    logic       do_switch;

    // hrdata is routed to the masters outside this block.
    logic unused_hrdata;
    assign unused_hrdata = ^hrdata;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            owner    <= 1'b0;
            dp_owner <= 1'b0;
            dp_valid <= 1'b0;
            last     <= 1'b1;
            hold_cnt <= 8'd0;
        end else begin
            owner    <= owner_nxt;
            dp_owner <= dp_owner_nxt;
            dp_valid <= dp_valid_nxt;
            last     <= last_nxt;
            hold_cnt <= hold_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        o_req  = owner ? m1_req  : m0_req;
        n_req  = owner ? m0_req  : m1_req;
        o_lock = owner ? m1_lock : m0_lock;
        // Count the beat being accepted this cycle so the limit takes effect
        // on exactly the MAX_HOLD-th accepted beat.
        beats  = {1'b0, hold_cnt} + {8'd0, htrans[1]};
        do_switch = hready && n_req && !o_lock &&
                    (!o_req || (htrans == HTRANS_IDLE) ||
                     (beats >= 9'(MAX_HOLD)));

        owner_nxt    = owner;
        dp_owner_nxt = dp_owner;
        dp_valid_nxt = dp_valid;
        last_nxt     = last;
        hold_nxt     = hold_cnt;

        if (hready) begin
            dp_owner_nxt = owner;
            dp_valid_nxt = htrans[1];
            if (htrans[1] && (hold_cnt != 8'hFF)) begin
                hold_nxt = hold_cnt + 8'd1;
            end
        end

        if (do_switch) begin
            owner_nxt = ~owner;
            last_nxt  = ~owner;
            hold_nxt  = 8'd0;
        end
    end

    // Output logic
    always_comb begin
        haddr     = owner ? m1_haddr  : m0_haddr;
        htrans    = owner ? m1_htrans : m0_htrans;
        hwrite    = owner ? m1_hwrite : m0_hwrite;
        hsize     = owner ? m1_hsize  : m0_hsize;
        hburst    = owner ? m1_hburst : m0_hburst;
        hmastlock = owner ? m1_lock   : m0_lock;
        // Write data belongs to whoever's transfer is in its data phase.
        hwdata    = dp_owner ? m1_hwdata : m0_hwdata;

        m0_grant  = !owner;
        m1_grant  = owner;
        m0_hready = hready && (!owner || (dp_valid && !dp_owner));
        m1_hready = hready && ( owner || (dp_valid &&  dp_owner));

        dbg_owner    = owner;
        dbg_dp_owner = dp_owner;
        dbg_dp_valid = dp_valid;
        dbg_last     = last;
        dbg_hold_cnt = hold_cnt;
    end

endmodule

// File: tb/tb_ahb_lite_master_arbiter.sv
module tb_ahb_lite_master_arbiter;

    logic        clk;
    logic        reset;
    logic        m0_req, m0_lock, m0_hwrite;
    logic [31:0] m0_haddr, m0_hwdata;
    logic [1:0]  m0_htrans;
    logic [2:0]  m0_hsize, m0_hburst;
    logic        m0_grant, m0_hready;
    logic        m1_req, m1_lock, m1_hwrite;
    logic [31:0] m1_haddr, m1_hwdata;
    logic [1:0]  m1_htrans;
    logic [2:0]  m1_hsize, m1_hburst;
    logic        m1_grant, m1_hready;
    logic [31:0] haddr, hwdata, hrdata;
    logic [1:0]  htrans;
    logic        hwrite, hmastlock, hready;
    logic [2:0]  hsize, hburst;
    logic        dbg_owner, dbg_dp_owner, dbg_dp_valid, dbg_last;
    logic [7:0]  dbg_hold_cnt;

    int pass_cnt  = 0;
    int total_cnt = 0;

    ahb_lite_master_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_HOLD(8)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_lock(m0_lock), .m0_haddr(m0_haddr), .m0_htrans(m0_htrans),
        .m0_hwrite(m0_hwrite), .m0_hsize(m0_hsize), .m0_hburst(m0_hburst),
        .m0_hwdata(m0_hwdata), .m0_grant(m0_grant), .m0_hready(m0_hready),
        .m1_req(m1_req), .m1_lock(m1_lock), .m1_haddr(m1_haddr), .m1_htrans(m1_htrans),
        .m1_hwrite(m1_hwrite), .m1_hsize(m1_hsize), .m1_hburst(m1_hburst),
        .m1_hwdata(m1_hwdata), .m1_grant(m1_grant), .m1_hready(m1_hready),
        .haddr(haddr), .htrans(htrans), .hwrite(hwrite), .hsize(hsize), .hburst(hburst),
        .hmastlock(hmastlock), .hwdata(hwdata), .hready(hready), .hrdata(hrdata),
        .dbg_owner(dbg_owner), .dbg_dp_owner(dbg_dp_owner), .dbg_dp_valid(dbg_dp_valid),
        .dbg_last(dbg_last), .dbg_hold_cnt(dbg_hold_cnt)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to the drive point of the next cycle.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        m0_req = 0; m0_lock = 0; m0_haddr = '0; m0_htrans = 2'b00; m0_hwrite = 0;
        m0_hsize = 3'b010; m0_hburst = 3'b000; m0_hwdata = '0;
        m1_req = 0; m1_lock = 0; m1_haddr = '0; m1_htrans = 2'b00; m1_hwrite = 0;
        m1_hsize = 3'b010; m1_hburst = 3'b000; m1_hwdata = '0;
        hready = 1; hrdata = 32'hCAFE_0000;
    endtask

    task automatic do_reset();
        idle_all();
        reset = 1;
        cyc();
        reset = 0;
    endtask

    task automatic test_reset();
        idle_all();
        reset = 1;
        m0_lock = 1; m0_haddr = 32'h44; m1_haddr = 32'h88; m1_lock = 0;
        cyc();
        @(negedge clk);
        total_cnt++; if (m0_grant !== 1'b1) $display("FAIL reset_m0_grant got %b exp 1", m0_grant); else pass_cnt++;
        total_cnt++; if (m1_grant !== 1'b0) $display("FAIL reset_m1_grant got %b exp 0", m1_grant); else pass_cnt++;
        total_cnt++; if (haddr !== 32'h44) $display("FAIL reset_haddr got %h exp 00000044", haddr); else pass_cnt++;
        total_cnt++; if (hmastlock !== 1'b1) $display("FAIL reset_hmastlock got %b exp 1", hmastlock); else pass_cnt++;
        total_cnt++; if (m0_hready !== 1'b1) $display("FAIL reset_m0_hready got %b exp 1", m0_hready); else pass_cnt++;
        total_cnt++; if (m1_hready !== 1'b0) $display("FAIL reset_m1_hready got %b exp 0", m1_hready); else pass_cnt++;
        total_cnt++; if (dbg_hold_cnt !== 8'd0) $display("FAIL reset_hold_cnt got %0d exp 0", dbg_hold_cnt); else pass_cnt++;
        total_cnt++; if (dbg_last !== 1'b1) $display("FAIL reset_last got %b exp 1", dbg_last); else pass_cnt++;
        total_cnt++; if (dbg_dp_valid !== 1'b0) $display("FAIL reset_dp_valid got %b exp 0", dbg_dp_valid); else pass_cnt++;
    endtask

    task automatic test_write();
        cyc();
        reset = 0; m0_lock = 0; m1_haddr = '0;
        m0_req = 1; m0_htrans = 2'b10; m0_hwrite = 1; m0_haddr = 32'h0000_0010; hready = 1;
        @(negedge clk);
        total_cnt++; if (m0_grant !== 1'b1) $display("FAIL wr_m0_grant got %b exp 1", m0_grant); else pass_cnt++;
        total_cnt++; if (haddr !== 32'h10) $display("FAIL wr_haddr got %h exp 00000010", haddr); else pass_cnt++;
        total_cnt++; if (htrans !== 2'b10) $display("FAIL wr_htrans got %b exp 10", htrans); else pass_cnt++;
        total_cnt++; if (hwrite !== 1'b1) $display("FAIL wr_hwrite got %b exp 1", hwrite); else pass_cnt++;
        total_cnt++; if (m1_hready !== 1'b0) $display("FAIL wr_m1_hready got %b exp 0", m1_hready); else pass_cnt++;
        cyc();
        m0_req = 0; m0_htrans = 2'b00; m0_hwrite = 0; m0_hwdata = 32'hDEAD_BEEF;
        @(negedge clk);
        total_cnt++; if (hwdata !== 32'hDEAD_BEEF) $display("FAIL wr_hwdata got %h exp deadbeef", hwdata); else pass_cnt++;
        total_cnt++; if (m0_hready !== 1'b1) $display("FAIL wr_m0_hready got %b exp 1", m0_hready); else pass_cnt++;
        total_cnt++; if (m1_hready !== 1'b0) $display("FAIL wr_dp_m1_hready got %b exp 0", m1_hready); else pass_cnt++;
        total_cnt++; if (dbg_hold_cnt !== 8'd1) $display("FAIL wr_hold_cnt got %0d exp 1", dbg_hold_cnt); else pass_cnt++;
        total_cnt++; if (dbg_dp_valid !== 1'b1) $display("FAIL wr_dp_valid got %b exp 1", dbg_dp_valid); else pass_cnt++;
    endtask

    task automatic test_switch();
        cyc();
        m1_req = 1; m1_htrans = 2'b10; m1_haddr = 32'h20;
        @(negedge clk);
        total_cnt++; if (m0_grant !== 1'b1) $display("FAIL sw_pre_m0_grant got %b exp 1", m0_grant); else pass_cnt++;
        total_cnt++; if (m1_grant !== 1'b0) $display("FAIL sw_pre_m1_grant got %b exp 0", m1_grant); else pass_cnt++;
        total_cnt++; if (htrans !== 2'b00) $display("FAIL sw_pre_htrans got %b exp 00", htrans); else pass_cnt++;
        cyc();
        @(negedge clk);
        total_cnt++; if (m1_grant !== 1'b1) $display("FAIL sw_m1_grant got %b exp 1", m1_grant); else pass_cnt++;
        total_cnt++; if (m0_grant !== 1'b0) $display("FAIL sw_m0_grant got %b exp 0", m0_grant); else pass_cnt++;
        total_cnt++; if (dbg_hold_cnt !== 8'd0) $display("FAIL sw_hold_cnt got %0d exp 0", dbg_hold_cnt); else pass_cnt++;
        total_cnt++; if (haddr !== 32'h20) $display("FAIL sw_haddr got %h exp 00000020", haddr); else pass_cnt++;
        total_cnt++; if (m1_hready !== 1'b1) $display("FAIL sw_m1_hready got %b exp 1", m1_hready); else pass_cnt++;
        total_cnt++; if (m0_hready !== 1'b0) $display("FAIL sw_m0_hready got %b exp 0", m0_hready); else pass_cnt++;
        total_cnt++; if (dbg_last !== 1'b1) $display("FAIL sw_last got %b exp 1", dbg_last); else pass_cnt++;
        cyc();
        m1_req = 0; m1_htrans = 2'b00; m1_hwdata = 32'h1234_5678;
        @(negedge clk);
        total_cnt++; if (hwdata !== 32'h1234_5678) $display("FAIL sw_hwdata got %h exp 12345678", hwdata); else pass_cnt++;
        total_cnt++; if (m1_hready !== 1'b1) $display("FAIL sw_dp_m1_hready got %b exp 1", m1_hready); else pass_cnt++;
    endtask

    // Both masters stream INCR bursts; ownership is expected to flip every
    // 8 accepted beats, each master resuming its own address sequence.
    task automatic test_round_robin();
        logic [31:0] last0, last1, exp_addr, exp_data, prev_data;
        int cnt0, cnt1, eo;
        logic g0_prev, g1_prev;
        last0 = '0; last1 = '0; cnt0 = 0; cnt1 = 0; g0_prev = 0; g1_prev = 0;
        prev_data = '0;
        do_reset();
        for (int k = 0; k < 32; k++) begin
            m0_req = 1; m0_hburst = 3'b001; m0_hwrite = 1;
            m0_htrans = (m0_grant && g0_prev) ? 2'b11 : 2'b10;
            m0_haddr  = 32'h1000 + 32'(4 * cnt0);
            m0_hwdata = 32'hD000_0000 | last0;
            m1_req = 1; m1_hburst = 3'b001; m1_hwrite = 1;
            m1_htrans = (m1_grant && g1_prev) ? 2'b11 : 2'b10;
            m1_haddr  = 32'h2000 + 32'(4 * cnt1);
            m1_hwdata = 32'hE000_0000 | last1;
            @(negedge clk);
            eo = (k / 8) % 2;
            exp_addr = ((eo == 1) ? 32'h2000 : 32'h1000) + 32'(4 * ((k / 16) * 8 + k % 8));
            exp_data = ((eo == 1) ? 32'hE000_0000 : 32'hD000_0000) | exp_addr;
            total_cnt++; if (m0_grant !== (eo == 0)) $display("FAIL rr_m0_grant k=%0d got %b exp %b", k, m0_grant, eo == 0); else pass_cnt++;
            total_cnt++; if (m1_grant !== (eo == 1)) $display("FAIL rr_m1_grant k=%0d got %b exp %b", k, m1_grant, eo == 1); else pass_cnt++;
            total_cnt++; if (haddr !== exp_addr) $display("FAIL rr_haddr k=%0d got %h exp %h", k, haddr, exp_addr); else pass_cnt++;
            total_cnt++; if (htrans !== ((k % 8 == 0) ? 2'b10 : 2'b11)) $display("FAIL rr_htrans k=%0d got %b", k, htrans); else pass_cnt++;
            total_cnt++; if (dbg_hold_cnt !== 8'(k % 8)) $display("FAIL rr_hold_cnt k=%0d got %0d exp %0d", k, dbg_hold_cnt, k % 8); else pass_cnt++;
            if (k > 0) begin
                total_cnt++; if (hwdata !== prev_data) $display("FAIL rr_hwdata k=%0d got %h exp %h", k, hwdata, prev_data); else pass_cnt++;
            end
            prev_data = exp_data;
            if (m0_grant && htrans[1]) begin last0 = m0_haddr; cnt0++; end
            if (m1_grant && htrans[1]) begin last1 = m1_haddr; cnt1++; end
            g0_prev = m0_grant; g1_prev = m1_grant;
            cyc();
        end
        m0_req = 0; m0_htrans = 2'b00; m0_hwdata = 32'hD000_0000 | last0;
        m1_req = 0; m1_htrans = 2'b00; m1_hwdata = 32'hE000_0000 | last1;
        @(negedge clk);
        total_cnt++; if (hwdata !== prev_data) $display("FAIL rr_final_hwdata got %h exp %h", hwdata, prev_data); else pass_cnt++;
    endtask

    task automatic test_lock();
        do_reset();
        for (int k = 0; k < 16; k++) begin
            m0_req = 1; m0_lock = 1; m0_hburst = 3'b111;
            m0_htrans = (k == 0) ? 2'b10 : 2'b11;
            m0_haddr = 32'h3000 + 32'(4 * k);
            m1_req = 1; m1_htrans = 2'b10; m1_haddr = 32'h6000;
            @(negedge clk);
            total_cnt++; if (m0_grant !== 1'b1) $display("FAIL lk_m0_grant k=%0d got %b exp 1", k, m0_grant); else pass_cnt++;
            total_cnt++; if (hmastlock !== 1'b1) $display("FAIL lk_hmastlock k=%0d got %b exp 1", k, hmastlock); else pass_cnt++;
            total_cnt++; if (m1_hready !== 1'b0) $display("FAIL lk_m1_hready k=%0d got %b exp 0", k, m1_hready); else pass_cnt++;
            if (k == 15) begin
                total_cnt++; if (dbg_hold_cnt !== 8'd15) $display("FAIL lk_hold_cnt got %0d exp 15", dbg_hold_cnt); else pass_cnt++;
            end
            cyc();
        end
        m0_lock = 0; m0_htrans = 2'b10; m0_hburst = 3'b001; m0_haddr = 32'h3100;
        @(negedge clk);
        total_cnt++; if (m0_grant !== 1'b1) $display("FAIL lk_drop_m0_grant got %b exp 1", m0_grant); else pass_cnt++;
        total_cnt++; if (hmastlock !== 1'b0) $display("FAIL lk_drop_hmastlock got %b exp 0", hmastlock); else pass_cnt++;
        cyc();
        m0_req = 0; m0_htrans = 2'b00;
        @(negedge clk);
        total_cnt++; if (m1_grant !== 1'b1) $display("FAIL lk_sw_m1_grant got %b exp 1", m1_grant); else pass_cnt++;
        total_cnt++; if (m0_grant !== 1'b0) $display("FAIL lk_sw_m0_grant got %b exp 0", m0_grant); else pass_cnt++;
        total_cnt++; if (m0_hready !== 1'b1) $display("FAIL lk_sw_m0_hready got %b exp 1", m0_hready); else pass_cnt++;
        total_cnt++; if (m1_hready !== 1'b1) $display("FAIL lk_sw_m1_hready got %b exp 1", m1_hready); else pass_cnt++;
        total_cnt++; if (dbg_dp_owner !== 1'b0) $display("FAIL lk_sw_dp_owner got %b exp 0", dbg_dp_owner); else pass_cnt++;
    endtask

    task automatic test_stall();
        do_reset();
        m0_req = 1; m0_htrans = 2'b10; m0_haddr = 32'h4000;
        m1_req = 1; m1_htrans = 2'b10; m1_haddr = 32'h5000;
        @(negedge clk);
        total_cnt++; if (m0_grant !== 1'b1) $display("FAIL st_m0_grant got %b exp 1", m0_grant); else pass_cnt++;
        cyc();
        for (int k = 0; k < 3; k++) begin
            m0_req = 0; m0_htrans = 2'b00; hready = 0;
            @(negedge clk);
            total_cnt++; if (m0_grant !== 1'b1) $display("FAIL st_wait_m0_grant k=%0d got %b exp 1", k, m0_grant); else pass_cnt++;
            total_cnt++; if (m1_grant !== 1'b0) $display("FAIL st_wait_m1_grant k=%0d got %b exp 0", k, m1_grant); else pass_cnt++;
            total_cnt++; if (m0_hready !== 1'b0) $display("FAIL st_wait_m0_hready k=%0d got %b exp 0", k, m0_hready); else pass_cnt++;
            total_cnt++; if (m1_hready !== 1'b0) $display("FAIL st_wait_m1_hready k=%0d got %b exp 0", k, m1_hready); else pass_cnt++;
            cyc();
        end
        hready = 1;
        @(negedge clk);
        total_cnt++; if (m0_grant !== 1'b1) $display("FAIL st_rel_m0_grant got %b exp 1", m0_grant); else pass_cnt++;
        total_cnt++; if (m0_hready !== 1'b1) $display("FAIL st_rel_m0_hready got %b exp 1", m0_hready); else pass_cnt++;
        total_cnt++; if (m1_hready !== 1'b0) $display("FAIL st_rel_m1_hready got %b exp 0", m1_hready); else pass_cnt++;
        cyc();
        @(negedge clk);
        total_cnt++; if (m1_grant !== 1'b1) $display("FAIL st_sw_m1_grant got %b exp 1", m1_grant); else pass_cnt++;
        total_cnt++; if (m0_grant !== 1'b0) $display("FAIL st_sw_m0_grant got %b exp 0", m0_grant); else pass_cnt++;
        total_cnt++; if (m1_hready !== 1'b1) $display("FAIL st_sw_m1_hready got %b exp 1", m1_hready); else pass_cnt++;
        total_cnt++; if (m0_hready !== 1'b0) $display("FAIL st_sw_m0_hready got %b exp 0", m0_hready); else pass_cnt++;
        total_cnt++; if (haddr !== 32'h5000) $display("FAIL st_sw_haddr got %h exp 00005000", haddr); else pass_cnt++;
    endtask

    // Continues from test_stall with master 1 owning the bus.
    task automatic test_reset_mid();
        cyc();
        m1_htrans = 2'b11; m1_haddr = 32'h5004;
        cyc();
        m1_htrans = 2'b11; m1_haddr = 32'h5008; m0_htrans = 2'b00; reset = 1;
        cyc();
        reset = 0;
        @(negedge clk);
        total_cnt++; if (m0_grant !== 1'b1) $display("FAIL rm_m0_grant got %b exp 1", m0_grant); else pass_cnt++;
        total_cnt++; if (m1_grant !== 1'b0) $display("FAIL rm_m1_grant got %b exp 0", m1_grant); else pass_cnt++;
        total_cnt++; if (m1_hready !== 1'b0) $display("FAIL rm_m1_hready got %b exp 0", m1_hready); else pass_cnt++;
        total_cnt++; if (htrans !== 2'b00) $display("FAIL rm_htrans got %b exp 00", htrans); else pass_cnt++;
        total_cnt++; if (dbg_dp_valid !== 1'b0) $display("FAIL rm_dp_valid got %b exp 0", dbg_dp_valid); else pass_cnt++;
        total_cnt++; if (dbg_hold_cnt !== 8'd0) $display("FAIL rm_hold_cnt got %0d exp 0", dbg_hold_cnt); else pass_cnt++;
    endtask

    initial begin
        reset = 1;
        idle_all();
        test_reset();
        test_write();
        test_switch();
        test_round_robin();
        test_lock();
        test_stall();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
